// File: rtl/pipe_phy_responder_if.sv
// PIPE MAC/PHY lane bundle for the behavioural PHY responder.
// The master side is the MAC plus link partner; the slave side is the PHY.
interface pipe_phy_responder_if #(
  parameter int DATA_BYTES = 8
);
  logic [1:0]              i_PowerDown;
  logic                    i_TxDetectRx;
  logic                    i_TxElecIdle;
  logic [8*DATA_BYTES-1:0] i_TxData;
  logic [DATA_BYTES-1:0]   i_TxDataK;
  logic [8*DATA_BYTES-1:0] i_FarData;
  logic [DATA_BYTES-1:0]   i_FarDataK;
  logic                    i_FarElecIdle;
  logic                    i_ReceiverPresent;
  logic                    o_PhyStatus;
  logic [2:0]              o_RxStatus;
  logic                    o_RxValid;
  logic                    o_RxElecIdle;
  logic [8*DATA_BYTES-1:0] o_RxData;
  logic [DATA_BYTES-1:0]   o_RxDataK;
  logic [8*DATA_BYTES-1:0] o_LaneData;
  logic [DATA_BYTES-1:0]   o_LaneDataK;
  logic                    o_LaneElecIdle;

  modport master (
    output i_PowerDown, i_TxDetectRx, i_TxElecIdle,
    output i_TxData, i_TxDataK,
    output i_FarData, i_FarDataK, i_FarElecIdle,
    output i_ReceiverPresent,
    input  o_PhyStatus, o_RxStatus, o_RxValid,
    input  o_RxElecIdle, o_RxData, o_RxDataK,
    input  o_LaneData, o_LaneDataK, o_LaneElecIdle
  );

  modport slave (
    input  i_PowerDown, i_TxDetectRx, i_TxElecIdle,
    input  i_TxData, i_TxDataK,
    input  i_FarData, i_FarDataK, i_FarElecIdle,
    input  i_ReceiverPresent,
    output o_PhyStatus, o_RxStatus, o_RxValid,
    output o_RxElecIdle, o_RxData, o_RxDataK,
    output o_LaneData, o_LaneDataK, o_LaneElecIdle
  );
endinterface

// File: rtl/pipe_phy_responder.sv
// Behavioural single-lane PIPE PHY: answers MAC control requests
// with PhyStatus/RxStatus and moves data between MAC and lane.
module pipe_phy_responder #(
  parameter int DATA_BYTES    = 8,
  parameter int RESET_CYCLES  = 8,
  parameter int DETECT_CYCLES = 16,
  parameter int PWR_CYCLES    = 8,
  parameter int LOCK_CYCLES   = 4
) (
  input logic                 i_PCLK,
  input logic                 i_Reset_n,
  pipe_phy_responder_if.slave pif
);
  localparam int W = 8 * DATA_BYTES;
  localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [7:0] DET_LAST = 8'(DETECT_CYCLES - 1);
  localparam logic [7:0] PWR_LAST = 8'(PWR_CYCLES - 1);
  localparam logic [7:0] LOCK_N   = 8'(LOCK_CYCLES);
  localparam logic [1:0] P0 = 2'b00;
  localparam logic [1:0] P1 = 2'b10;

  typedef enum logic [2:0] {
    S_RESET_WAIT,
    S_IDLE,
    S_PWR_CHG,
    S_DETECT,
    S_DETECT_HOLD
  } state_t;

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d;
  logic [1:0] pwr, pwr_d;
  logic [1:0] tgt, tgt_d;
  logic       phy_st, phy_st_d;
  logic [2:0] rx_st, rx_st_d;

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    pwr_d    = pwr;
    tgt_d    = tgt;
    phy_st_d = 1'b0;
    rx_st_d  = 3'b000;
    unique case (state)
      S_RESET_WAIT: begin
        if (cnt == RST_LAST) begin
          pwr_d   = pif.i_PowerDown;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          phy_st_d = 1'b1;
          cnt_d    = cnt + 8'd1;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        // A power request outranks a detect request
        if (pif.i_PowerDown != pwr) begin
          tgt_d   = pif.i_PowerDown;
          state_d = S_PWR_CHG;
        end else if (pif.i_TxDetectRx && pwr == P1) begin
          state_d = S_DETECT;
        end
      end
      S_PWR_CHG: begin
        if (pif.i_PowerDown != tgt) begin
          tgt_d = pif.i_PowerDown;
          cnt_d = '0;
        end else if (cnt == PWR_LAST) begin
          pwr_d    = tgt;
          phy_st_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_DETECT: begin
        if (!pif.i_TxDetectRx) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt == DET_LAST) begin
          phy_st_d = 1'b1;
          rx_st_d  = pif.i_ReceiverPresent ? 3'b011 : 3'b000;
          cnt_d    = '0;
          state_d  = S_DETECT_HOLD;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_DETECT_HOLD: begin
        if (!pif.i_TxDetectRx) state_d = S_IDLE;
      end
      default: state_d = S_RESET_WAIT;
    endcase
  end

  always_ff @(posedge i_PCLK) begin
    if (!i_Reset_n) begin
      state  <= S_RESET_WAIT;
      cnt    <= '0;
      pwr    <= P1;
      tgt    <= P1;
      phy_st <= 1'b1;
      rx_st  <= 3'b000;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      pwr    <= pwr_d;
      tgt    <= tgt_d;
      phy_st <= phy_st_d;
      rx_st  <= rx_st_d;
    end
  end

  logic                  p0, rx_good, tx_idle;
  logic [7:0]            lock, lock_nx;
  logic                  rx_valid, rx_eidle;
  logic [W-1:0]          rx_data;
  logic [DATA_BYTES-1:0] rx_datak;
  logic                  lane_eidle;
  logic [W-1:0]          lane_data;
  logic [DATA_BYTES-1:0] lane_datak;

  assign p0      = (pwr == P0);
  assign rx_good = p0 & ~pif.i_FarElecIdle;
  assign tx_idle = pif.i_TxElecIdle | ~p0;
  assign lock_nx = (lock == 8'hFF) ? lock : lock + 8'd1;

  always_ff @(posedge i_PCLK) begin
    if (!i_Reset_n) begin
      lock       <= '0;
      rx_valid   <= 1'b0;
      rx_eidle   <= 1'b1;
      rx_data    <= '0;
      rx_datak   <= '0;
      lane_eidle <= 1'b1;
      lane_data  <= '0;
      lane_datak <= '0;
    end else begin
      lock       <= rx_good ? lock_nx : 8'd0;
      rx_valid   <= rx_good && (lock_nx >= LOCK_N);
      rx_eidle   <= p0 ? pif.i_FarElecIdle : 1'b1;
      rx_data    <= rx_good ? pif.i_FarData : '0;
      rx_datak   <= rx_good ? pif.i_FarDataK : '0;
      lane_eidle <= tx_idle;
      lane_data  <= tx_idle ? '0 : pif.i_TxData;
      lane_datak <= tx_idle ? '0 : pif.i_TxDataK;
    end
  end

  assign pif.o_PhyStatus    = phy_st;
  assign pif.o_RxStatus     = rx_st;
  assign pif.o_RxValid      = rx_valid;
  assign pif.o_RxElecIdle   = rx_eidle;
  assign pif.o_RxData       = rx_data;
  assign pif.o_RxDataK      = rx_datak;
  assign pif.o_LaneData     = lane_data;
  assign pif.o_LaneDataK    = lane_datak;
  assign pif.o_LaneElecIdle = lane_eidle;
endmodule
